// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer: the controller state encoding.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider for the timer: emits a one-cycle tick every div+1 enabled clocks.
// A clear restarts the division from zero and swallows any tick due that cycle.
module tick_prescaler #(
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [PRE_WIDTH-1:0] div,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] cnt_q;
  logic [PRE_WIDTH-1:0] cnt_d;

  assign tick = enable && !clear && (cnt_q == div);

  // Next prescaler count: clear wins, otherwise count up and wrap on the tick.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so all flops update together at the edge.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable timer: counts prescaled ticks up to a latched terminal value,
// pulses cout on the terminal tick, then reloads (periodic) or parks in DONE.
module prog_timer
  import timer_pkg::*;
#(
  parameter int BUS_WIDTH = 12,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 periodic,
  input  logic [BUS_WIDTH-1:0] load_val,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic                 cout,
  output logic [BUS_WIDTH-1:0] q,
  output logic                 busy,
  output logic                 done
);

  timer_state_e         state_q, state_d;
  logic [BUS_WIDTH-1:0] count_q, count_d;
  logic [BUS_WIDTH-1:0] term_q, term_d;
  logic [PRE_WIDTH-1:0] div_q, div_d;
  logic                 periodic_q, periodic_d;
  logic                 cout_q, cout_d;
  logic                 tick;

  // Start and stop both restart the division; a pending tick is dropped.
  tick_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (start | stop),
    .enable(state_q == RUN),
    .div   (div_q),
    .tick  (tick)
  );

  // Controller: stop beats start, start beats the tick; cout only on a terminal tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    term_d     = term_q;
    div_d      = div_q;
    periodic_d = periodic_q;
    cout_d     = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start) begin
      state_d    = RUN;
      count_d    = '0;
      term_d     = load_val;
      div_d      = prescale;
      periodic_d = periodic;
    end else if (tick) begin
      if (count_q < term_q) begin
        count_d = count_q + 1'b1;
      end else begin
        cout_d = 1'b1;
        if (periodic_q) begin
          count_d = '0;
        end else begin
          state_d = DONE;
        end
      end
    end
  end

  // State, count, latched configuration and the registered cout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      term_q     <= '0;
      div_q      <= '0;
      periodic_q <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      term_q     <= term_d;
      div_q      <= div_d;
      periodic_q <= periodic_d;
      cout_q     <= cout_d;
    end
  end

  assign cout = cout_q;
  assign q    = count_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: the driver queues expected cout pulses and
// per-cycle output snapshots; a monitor on the falling edge pops and compares.
module tb_prog_timer;

  localparam int BW = 12;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          periodic;
  logic [BW-1:0] load_val;
  logic [PW-1:0] prescale;
  logic          cout;
  logic [BW-1:0] q;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  prog_timer #(
    .BUS_WIDTH(BW),
    .PRE_WIDTH(PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .periodic(periodic),
    .load_val(load_val),
    .prescale(prescale),
    .cout    (cout),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    int    cyc;
    int    qv;
    bit    busy;
    bit    done;
    bit    cout;
    string tag;
  } snap_t;

  snap_t exp_snap[$];
  int    exp_cout[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_mis = 0;
  bit    finishing = 1'b0;

  // cyc = number of rising edges so far; stable while sampled at the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, req);
    end
  endtask

  function automatic void push_snap(input int c, input int qv, input bit b, input bit d,
                                    input bit co, input string tag);
    snap_t s;
    int    i;
    s = '{c, qv, b, d, co, tag};
    i = 0;
    while (i < exp_snap.size() && exp_snap[i].cyc <= c) i++;
    exp_snap.insert(i, s);
  endfunction

  function automatic void push_cout(input int c);
    int i;
    i = 0;
    while (i < exp_cout.size() && exp_cout[i] <= c) i++;
    exp_cout.insert(i, c);
  endfunction

  // Monitor: compare cout pulses and scheduled snapshots, then summarise at the end.
  always @(negedge clk) begin
    snap_t s;
    while (exp_cout.size() > 0 && exp_cout[0] < cyc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL cout_missing @cyc %0d: got no pulse, want pulse at cyc %0d", cyc, exp_cout[0]);
      void'(exp_cout.pop_front());
    end
    if (cout === 1'b1) begin
      n_cmp++;
      if (exp_cout.size() > 0 && exp_cout[0] == cyc) begin
        void'(exp_cout.pop_front());
      end else begin
        n_mis++;
        $display("FAIL cout_unexpected @cyc %0d: got 1, want 0", cyc);
      end
    end
    while (exp_snap.size() > 0 && exp_snap[0].cyc <= cyc) begin
      s = exp_snap.pop_front();
      if (s.cyc < cyc) begin
        n_cmp++;
        n_mis++;
        $display("FAIL %s_stale @cyc %0d: got late sample, want cyc %0d", s.tag, cyc, s.cyc);
      end else begin
        check({s.tag, ".q"},    q,    s.qv);
        check({s.tag, ".busy"}, busy, s.busy);
        check({s.tag, ".done"}, done, s.done);
        check({s.tag, ".cout"}, cout, s.cout);
      end
    end
    if (finishing) begin
      foreach (exp_cout[i]) begin
        n_cmp++;
        n_mis++;
        $display("FAIL cout_never @end: got no pulse, want pulse at cyc %0d", exp_cout[i]);
      end
      foreach (exp_snap[i]) begin
        n_cmp++;
        n_mis++;
        $display("FAIL %s_unsampled @end: got nothing, want sample at cyc %0d", exp_snap[i].tag, exp_snap[i].cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
    end
  end

  // One start pulse; afterwards the config inputs are scrambled to prove they are ignored.
  task automatic do_start(input int lv, input int ps, input bit per);
    logic [BW-1:0] lv_w;
    logic [PW-1:0] ps_w;
    lv_w     = lv[BW-1:0];
    ps_w     = ps[PW-1:0];
    start    = 1'b1;
    load_val = lv_w;
    prescale = ps_w;
    periodic = per;
    @(negedge clk);
    start    = 1'b0;
    load_val = lv_w ^ 12'h5A5;
    prescale = ps_w + 8'd3;
    periodic = ~per;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver: directed scenarios; expectations are queued before the stimulus edge.
  initial begin
    int s;
    int s2;
    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    load_val = '0;
    prescale = '0;
    wait_cyc(2);

    // Reset state, with start held off by reset.
    s = cyc + 1;
    push_snap(s,     0, 0, 0, 0, "rst0");
    push_snap(s + 1, 0, 0, 0, 0, "rst1");
    push_snap(s + 2, 0, 0, 0, 0, "rst2");
    start    = 1'b1;
    load_val = 12'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(1);

    // One-shot, terminal 3, no prescale: cout at clock 4, then DONE holding q=3.
    s = cyc + 1;
    push_snap(s,     0, 1, 0, 0, "os_k0");
    push_snap(s + 1, 1, 1, 0, 0, "os_k1");
    push_snap(s + 2, 2, 1, 0, 0, "os_k2");
    push_snap(s + 3, 3, 1, 0, 0, "os_k3");
    push_snap(s + 4, 3, 0, 1, 1, "os_k4");
    push_snap(s + 5, 3, 0, 1, 0, "os_k5");
    push_snap(s + 6, 3, 0, 1, 0, "os_k6");
    push_cout(s + 4);
    do_start(3, 0, 0);
    wait_cyc(7);

    // Periodic, terminal 2, prescale 1: cout every 6 clocks for 5 periods.
    s = cyc + 1;
    for (int k = 0; k <= 30; k++) begin
      push_snap(s + k, (k / 2) % 3, 1, 0, (k > 0) && (k % 6 == 0), "per");
    end
    for (int p = 1; p <= 5; p++) push_cout(s + 6 * p);
    do_start(2, 1, 1);
    wait_cyc(30);
    push_snap(s + 31, 0, 0, 0, 0, "per_stop");
    do_stop();
    wait_cyc(1);

    // Stop at q=5 of terminal 9.
    s = cyc + 1;
    for (int k = 0; k <= 5; k++) push_snap(s + k, k, 1, 0, 0, "stop_run");
    push_snap(s + 6, 0, 0, 0, 0, "stop_idle0");
    push_snap(s + 7, 0, 0, 0, 0, "stop_idle1");
    do_start(9, 0, 0);
    wait_cyc(5);
    do_stop();
    wait_cyc(1);

    // Stop on the terminal tick itself suppresses cout.
    s = cyc + 1;
    for (int k = 0; k <= 2; k++) push_snap(s + k, k, 1, 0, 0, "stop_term_run");
    push_snap(s + 3, 0, 0, 0, 0, "stop_term0");
    push_snap(s + 4, 0, 0, 0, 0, "stop_term1");
    do_start(2, 0, 0);
    wait_cyc(2);
    do_stop();
    wait_cyc(1);

    // Start and stop together during RUN: stop wins.
    s = cyc + 1;
    for (int k = 0; k <= 3; k++) push_snap(s + k, k, 1, 0, 0, "ss_run");
    push_snap(s + 4, 0, 0, 0, 0, "ss_idle0");
    push_snap(s + 5, 0, 0, 0, 0, "ss_idle1");
    do_start(9, 0, 1);
    wait_cyc(3);
    start    = 1'b1;
    stop     = 1'b1;
    load_val = 12'd1;
    prescale = 8'd0;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    wait_cyc(1);

    // Restart mid-run exactly when a tick is due; new terminal 1 gives cout 2 clocks later.
    s  = cyc + 1;
    s2 = s + 9;
    for (int k = 0; k <= 8; k++) push_snap(s + k, k / 3, 1, 0, 0, "rs_old");
    push_snap(s2,     0, 1, 0, 0, "rs_k0");
    push_snap(s2 + 1, 1, 1, 0, 0, "rs_k1");
    push_snap(s2 + 2, 1, 0, 1, 1, "rs_k2");
    push_snap(s2 + 3, 1, 0, 1, 0, "rs_k3");
    push_cout(s2 + 2);
    do_start(9, 2, 0);
    wait_cyc(8);
    do_start(1, 0, 0);
    wait_cyc(3);

    // Terminal 0: cout one clock after start, count stays 0.
    s = cyc + 1;
    push_snap(s,     0, 1, 0, 0, "zero_k0");
    push_snap(s + 1, 0, 0, 1, 1, "zero_k1");
    push_snap(s + 2, 0, 0, 1, 0, "zero_k2");
    push_cout(s + 1);
    do_start(0, 0, 0);
    wait_cyc(2);

    // Full-scale terminal: q reaches 4095 and holds without wrapping.
    s = cyc + 1;
    push_snap(s + 10,   10,   1, 0, 0, "max_k10");
    push_snap(s + 4095, 4095, 1, 0, 0, "max_top");
    push_snap(s + 4096, 4095, 0, 1, 1, "max_cout");
    push_snap(s + 4097, 4095, 0, 1, 0, "max_hold");
    push_cout(s + 4096);
    do_start(4095, 0, 0);
    wait_cyc(4097);

    // Reset during RUN at q=7 with start asserted alongside it.
    s = cyc + 1;
    push_snap(s + 7,  7, 1, 0, 0, "mrst_run");
    push_snap(s + 8,  0, 0, 0, 0, "mrst0");
    push_snap(s + 9,  0, 0, 0, 0, "mrst1");
    push_snap(s + 10, 0, 0, 0, 0, "mrst2");
    do_start(20, 0, 1);
    wait_cyc(7);
    rst      = 1'b1;
    start    = 1'b1;
    load_val = 12'd3;
    prescale = 8'd0;
    wait_cyc(2);
    rst   = 1'b0;
    start = 1'b0;
    wait_cyc(1);

    // Recovery after reset: periodic terminal 1, cout every 2 clocks.
    s = cyc + 1;
    push_snap(s + 1, 1, 1, 0, 0, "rec_k1");
    push_snap(s + 2, 0, 1, 0, 1, "rec_k2");
    push_snap(s + 5, 0, 0, 0, 0, "rec_stop");
    push_cout(s + 2);
    push_cout(s + 4);
    do_start(1, 0, 1);
    wait_cyc(4);
    do_stop();
    wait_cyc(2);

    finishing = 1'b1;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
